// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU bus and a DMA master, round-robin on contention.
// Define MEM_ARB_CPU_PRIORITY_EN for fixed CPU-wins priority (RR_FIRST then unused).
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter bit RR_FIRST   = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [31:0]           cpu_wdata,
   input  logic [3:0]            cpu_wmask,
   input  logic                  cpu_rstrb,
   output logic [31:0]           cpu_rdata,
   output logic                  cpu_rbusy,
   output logic                  cpu_wbusy,
   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [ADDR_WIDTH-1:0] dma_addr,
   input  logic [31:0]           dma_wdata,
   input  logic [3:0]            dma_wmask,
   output logic                  dma_ack,
   output logic [31:0]           dma_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_wmask,
   output logic                  mem_rstrb,
   input  logic [31:0]           mem_rdata
);
   logic                  w_cpu_live, w_cpu_elig, w_dma_elig, w_gnt_cpu, w_gnt_dma, w_cpu_ret;
   logic                  r_pend_v, r_pend_rd, r_dma_out, r_ret_v, r_ret_cpu;
   logic [ADDR_WIDTH-1:0] r_pend_addr;
   logic [31:0]           r_pend_wdata, r_cpu_rdata;
   logic [3:0]            r_pend_wmask;
   // a pulse arriving while a request is already pending is ignored
   assign w_cpu_live = (cpu_rstrb | (|cpu_wmask)) & ~r_pend_v;
   assign w_cpu_elig = w_cpu_live | r_pend_v;
   assign w_dma_elig = dma_req & ~r_dma_out;
`ifdef MEM_ARB_CPU_PRIORITY_EN
   assign w_gnt_cpu  = w_cpu_elig;
`else
   logic r_last_dma;
   assign w_gnt_cpu  = w_cpu_elig & (~w_dma_elig | r_last_dma);
   always_ff @(posedge clk)
      if (reset) r_last_dma <= !RR_FIRST;
      else if (w_gnt_cpu | w_gnt_dma) r_last_dma <= w_gnt_dma;
`endif
   assign w_gnt_dma  = w_dma_elig & ~w_gnt_cpu;
   assign w_cpu_ret  = r_ret_v & r_ret_cpu;
   always_comb begin
      mem_addr  = w_gnt_cpu ? (w_cpu_live ? cpu_addr : r_pend_addr) : w_gnt_dma ? dma_addr : '0;
      mem_wdata = w_gnt_cpu ? (w_cpu_live ? cpu_wdata : r_pend_wdata) : w_gnt_dma ? dma_wdata : '0;
      mem_wmask = w_gnt_cpu ? (w_cpu_live ? cpu_wmask : r_pend_wmask) : (w_gnt_dma & dma_we) ? dma_wmask : 4'h0;
      mem_rstrb = w_gnt_cpu ? (w_cpu_live ? cpu_rstrb : r_pend_rd) : (w_gnt_dma & ~dma_we);
   end
   assign cpu_rdata = w_cpu_ret ? mem_rdata : r_cpu_rdata;
   assign dma_rdata = (r_ret_v & ~r_ret_cpu) ? mem_rdata : '0;
   assign dma_ack   = r_dma_out;
   assign cpu_rbusy = r_pend_v & r_pend_rd;
   assign cpu_wbusy = r_pend_v & ~r_pend_rd;
   always_ff @(posedge clk)
      if (reset) begin
         r_pend_v    <= 1'b0;
         r_dma_out   <= 1'b0;
         r_ret_v     <= 1'b0;
         r_ret_cpu   <= 1'b0;
         r_cpu_rdata <= '0;
      end else begin
         r_pend_v  <= w_cpu_elig & ~w_gnt_cpu;
         r_dma_out <= w_gnt_dma;
         r_ret_v   <= mem_rstrb;
         r_ret_cpu <= w_gnt_cpu;
         if (w_cpu_ret) r_cpu_rdata <= mem_rdata;
      end
   // payload only matters while r_pend_v is set, so it needs no reset
   always_ff @(posedge clk)
      if (w_cpu_live) begin
         r_pend_addr  <= cpu_addr;
         r_pend_wdata <= cpu_wdata;
         r_pend_wmask <= cpu_wmask;
         r_pend_rd    <= cpu_rstrb;
      end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
   logic        clk = 1'b0, reset = 1'b1;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
   logic [3:0]  cpu_wmask = '0;
   logic        cpu_rstrb = 1'b0, cpu_rbusy, cpu_wbusy;
   logic        dma_req = 1'b0, dma_we = 1'b0, dma_ack;
   logic [31:0] dma_addr = '0, dma_wdata = '0, dma_rdata;
   logic [3:0]  dma_wmask = '0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb;
   int vectors = 0, miscompares = 0;
   logic [31:0] phys[16];
   logic [31:0] ref_mem[16];
   bit          m_pend, m_pend_rd, m_dma_out, m_dma_rd, m_last_dma, m_cret, e_live, e_cw, e_dw, e_rstrb;
   logic [31:0] m_pa, m_pd, m_cexp, m_chold, m_dexp, e_addr, e_wdata;
   logic [3:0]  m_pm, e_wmask;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_rstrb(cpu_rstrb),
      .cpu_rdata(cpu_rdata), .cpu_rbusy(cpu_rbusy), .cpu_wbusy(cpu_wbusy),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_wmask(dma_wmask), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // the bench plays the memory: registered read data, writes land at the issue edge
   always @(posedge clk) begin
      if (mem_rstrb) mem_rdata <= phys[mem_addr[5:2]];
      for (int b = 0; b < 4; b++)
         if (mem_wmask[b]) phys[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   function automatic logic [31:0] init_word(int i);
      return (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   task automatic idle();
      cpu_rstrb = 1'b0; cpu_wmask = 4'h0; dma_req = 1'b0;
   endtask

   task automatic next();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; idle(); next(); reset = 1'b0;
   endtask

   task automatic model_reset();
      m_pend = 0; m_dma_out = 0; m_last_dma = 1; m_cret = 0; m_chold = '0;
   endtask

   // who gets the port and what it should see, from the arbitration rules
   task automatic model_eval();
      bit ce, de;
      e_live = (cpu_rstrb || cpu_wmask != 0) && !m_pend;
      ce = e_live || m_pend;
      de = dma_req && !m_dma_out;
      e_cw = ce && (!de || m_last_dma);
      e_dw = de && !e_cw;
      e_addr = '0; e_wdata = '0; e_wmask = '0; e_rstrb = 0;
      if (e_cw && e_live) begin
         e_addr = cpu_addr; e_wdata = cpu_wdata; e_wmask = cpu_wmask; e_rstrb = cpu_rstrb;
      end else if (e_cw) begin
         e_addr = m_pa; e_wdata = m_pd; e_wmask = m_pm; e_rstrb = m_pend_rd;
      end else if (e_dw) begin
         e_addr = dma_addr; e_wdata = dma_wdata; e_wmask = dma_we ? dma_wmask : 4'h0; e_rstrb = !dma_we;
      end
   endtask

   task automatic model_adv();
      if (m_cret) m_chold = m_cexp;
      m_cret = e_cw && e_rstrb;
      if (e_rstrb) begin m_cexp = ref_mem[e_addr[5:2]]; m_dexp = ref_mem[e_addr[5:2]]; end
      m_dma_out = e_dw;
      m_dma_rd = e_dw && e_rstrb;
      for (int b = 0; b < 4; b++)
         if (e_wmask[b]) ref_mem[e_addr[5:2]][8*b +: 8] = e_wdata[8*b +: 8];
      if (e_live && !e_cw) begin
         m_pend = 1; m_pend_rd = cpu_rstrb; m_pa = cpu_addr; m_pd = cpu_wdata; m_pm = cpu_wmask;
      end else if (e_cw) m_pend = 0;
      if (e_cw || e_dw) m_last_dma = e_dw;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      vectors++; if ({cpu_rbusy, cpu_wbusy, dma_ack} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {cpu_rbusy, cpu_wbusy, dma_ack}); end
      vectors++; if (cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_cpu_rdata got %h want 0", cpu_rdata); end
      vectors++; if ({mem_wmask, mem_rstrb} !== 5'b0) begin miscompares++; $display("FAIL reset_mem_idle got %b want 0", {mem_wmask, mem_rstrb}); end
      next();
   endtask

   task automatic test_cpu_read_alone();
      do_reset();
      cpu_addr = 32'h10; cpu_rstrb = 1'b1;
      @(negedge clk);
      vectors++; if (mem_rstrb !== 1'b1 || mem_addr !== 32'h10) begin miscompares++; $display("FAIL rd_alone_issue got %b/%h want 1/10", mem_rstrb, mem_addr); end
      vectors++; if (cpu_rbusy !== 1'b0) begin miscompares++; $display("FAIL rd_alone_busy0 got %b want 0", cpu_rbusy); end
      next(); cpu_rstrb = 1'b0;
      @(negedge clk);
      vectors++; if (cpu_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_alone_data got %h want deadbeef", cpu_rdata); end
      vectors++; if (cpu_rbusy !== 1'b0) begin miscompares++; $display("FAIL rd_alone_busy1 got %b want 0", cpu_rbusy); end
      next();
   endtask

   task automatic test_contention();
      do_reset();
      cpu_addr = 32'h10; cpu_rstrb = 1'b1; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
      @(negedge clk);
      vectors++; if (mem_addr !== 32'h10 || mem_rstrb !== 1'b1) begin miscompares++; $display("FAIL cont_first_cpu got %h want 10", mem_addr); end
      next(); cpu_rstrb = 1'b0;
      @(negedge clk);
      vectors++; if (mem_addr !== 32'h20 || mem_rstrb !== 1'b1) begin miscompares++; $display("FAIL cont_dma_next got %h want 20", mem_addr); end
      vectors++; if (cpu_rdata !== 32'hDEADBEEF || cpu_rbusy !== 1'b0) begin miscompares++; $display("FAIL cont_cpu_data got %h/%b want deadbeef/0", cpu_rdata, cpu_rbusy); end
      next(); cpu_addr = 32'h24; cpu_rstrb = 1'b1;
      @(negedge clk);
      vectors++; if (dma_ack !== 1'b1 || dma_rdata !== init_word(8)) begin miscompares++; $display("FAIL cont_dma_ack got %b/%h want 1/%h", dma_ack, dma_rdata, init_word(8)); end
      vectors++; if (mem_addr !== 32'h24) begin miscompares++; $display("FAIL cont_cpu_while_out got %h want 24", mem_addr); end
      next(); cpu_addr = 32'h10;
      @(negedge clk);
      vectors++; if (mem_addr !== 32'h20) begin miscompares++; $display("FAIL cont_dma_wins got %h want 20", mem_addr); end
      vectors++; if (cpu_rdata !== init_word(9) || cpu_rbusy !== 1'b0) begin miscompares++; $display("FAIL cont_cpu_data2 got %h/%b want %h/0", cpu_rdata, cpu_rbusy, init_word(9)); end
      next(); cpu_rstrb = 1'b0; dma_req = 1'b0;
      @(negedge clk);
      vectors++; if (mem_addr !== 32'h10 || mem_rstrb !== 1'b1) begin miscompares++; $display("FAIL cont_pend_issue got %h want 10", mem_addr); end
      vectors++; if (cpu_rbusy !== 1'b1 || dma_ack !== 1'b1) begin miscompares++; $display("FAIL cont_rbusy got %b/%b want 1/1", cpu_rbusy, dma_ack); end
      next();
      @(negedge clk);
      vectors++; if (cpu_rbusy !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL cont_pend_data got %b/%h want 0/deadbeef", cpu_rbusy, cpu_rdata); end
      next();
   endtask

   task automatic test_cpu_write();
      do_reset();
      cpu_addr = 32'h10; cpu_rstrb = 1'b1;
      @(negedge clk);
      vectors++; if (mem_rstrb !== 1'b1) begin miscompares++; $display("FAIL wr_pre_read got %b want 1", mem_rstrb); end
      next(); cpu_rstrb = 1'b0; cpu_addr = 32'h8; cpu_wdata = 32'h55; cpu_wmask = 4'hF;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h30;
      @(negedge clk);
      vectors++; if (mem_addr !== 32'h30 || mem_wmask !== 4'h0) begin miscompares++; $display("FAIL wr_dma_wins got %h/%h want 30/0", mem_addr, mem_wmask); end
      next(); cpu_wmask = 4'h0; dma_req = 1'b0;
      @(negedge clk);
      vectors++; if (cpu_wbusy !== 1'b1) begin miscompares++; $display("FAIL wr_wbusy1 got %b want 1", cpu_wbusy); end
      vectors++; if (mem_wmask !== 4'hF || mem_addr !== 32'h8 || mem_wdata !== 32'h55) begin miscompares++; $display("FAIL wr_issue got %h/%h/%h want f/8/55", mem_wmask, mem_addr, mem_wdata); end
      next();
      @(negedge clk);
      vectors++; if (cpu_wbusy !== 1'b0) begin miscompares++; $display("FAIL wr_wbusy0 got %b want 0", cpu_wbusy); end
      next(); cpu_rstrb = 1'b1;
      next(); cpu_rstrb = 1'b0;
      @(negedge clk);
      vectors++; if (cpu_rdata !== 32'h55) begin miscompares++; $display("FAIL wr_readback got %h want 55", cpu_rdata); end
      next();
   endtask

   task automatic test_dma_stream();
      int acks = 0, issues = 0;
      do_reset();
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h1C;
      for (int i = 0; i < 9; i++) begin
         if (i == 8) dma_req = 1'b0;
         @(negedge clk);
         if (i < 8) begin
            vectors++; if (mem_rstrb !== (i % 2 == 0)) begin miscompares++; $display("FAIL dma_rate_c%0d got %b want %b", i, mem_rstrb, i % 2 == 0); end
         end
         if (dma_ack === 1'b1) begin
            acks++;
            vectors++; if (dma_rdata !== init_word(7)) begin miscompares++; $display("FAIL dma_stream_data got %h want %h", dma_rdata, init_word(7)); end
         end
         if (mem_rstrb === 1'b1) issues++;
         next();
      end
      vectors++; if (acks != 4 || issues != 4) begin miscompares++; $display("FAIL dma_stream_count got %0d/%0d want 4/4", acks, issues); end
   endtask

   task automatic test_reset_midop();
      do_reset();
      cpu_addr = 32'h10; cpu_rstrb = 1'b1;
      next(); cpu_rstrb = 1'b0; cpu_addr = 32'hC; cpu_wdata = 32'hA5; cpu_wmask = 4'hF;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h30; reset = 1'b1;
      @(negedge clk);
      vectors++; if (mem_wmask !== 4'h0) begin miscompares++; $display("FAIL rst_mid_nowrite got %h want 0", mem_wmask); end
      next(); reset = 1'b0; idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++; if ({cpu_rbusy, cpu_wbusy, dma_ack} !== 3'b000 || mem_wmask !== 4'h0) begin miscompares++; $display("FAIL rst_mid_quiet_c%0d got %b/%h want 000/0", i, {cpu_rbusy, cpu_wbusy, dma_ack}, mem_wmask); end
         next();
      end
      vectors++; if (cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_mid_rdata got %h want 0", cpu_rdata); end
      vectors++; if (phys[3] !== init_word(3)) begin miscompares++; $display("FAIL rst_mid_mem got %h want %h", phys[3], init_word(3)); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 16; i++) ref_mem[i] = phys[i];
      model_reset();
      for (int n = 0; n < 600; n++) begin
         cpu_rstrb = 1'b0; cpu_wmask = 4'h0;
         if ((!m_pend && $urandom % 3 == 0) || $urandom % 16 == 0) begin
            cpu_addr = 32'($urandom_range(0, 15)) << 2;
            cpu_wdata = $urandom;
            if ($urandom % 2 == 1) cpu_rstrb = 1'b1; else cpu_wmask = 4'($urandom_range(1, 15));
         end
         if (m_dma_out || (!dma_req && $urandom % 3 == 0)) begin
            dma_req = 1'($urandom % 2);
            dma_we = 1'($urandom % 2);
            dma_addr = 32'($urandom_range(0, 15)) << 2;
            dma_wdata = $urandom;
            dma_wmask = 4'($urandom);
         end
         @(negedge clk);
         model_eval();
         vectors++; if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin miscompares++; $display("FAIL rnd_addr_data c%0d got %h/%h want %h/%h", n, mem_addr, mem_wdata, e_addr, e_wdata); end
         vectors++; if (mem_wmask !== e_wmask || mem_rstrb !== e_rstrb) begin miscompares++; $display("FAIL rnd_strobes c%0d got %h/%b want %h/%b", n, mem_wmask, mem_rstrb, e_wmask, e_rstrb); end
         vectors++; if (cpu_rbusy !== (m_pend && m_pend_rd) || cpu_wbusy !== (m_pend && !m_pend_rd)) begin miscompares++; $display("FAIL rnd_busy c%0d got %b%b want %b%b", n, cpu_rbusy, cpu_wbusy, m_pend && m_pend_rd, m_pend && !m_pend_rd); end
         vectors++; if (dma_ack !== m_dma_out) begin miscompares++; $display("FAIL rnd_ack c%0d got %b want %b", n, dma_ack, m_dma_out); end
         vectors++; if (cpu_rdata !== (m_cret ? m_cexp : m_chold)) begin miscompares++; $display("FAIL rnd_cpu_rdata c%0d got %h want %h", n, cpu_rdata, m_cret ? m_cexp : m_chold); end
         if (m_dma_out && m_dma_rd) begin
            vectors++; if (dma_rdata !== m_dexp) begin miscompares++; $display("FAIL rnd_dma_rdata c%0d got %h want %h", n, dma_rdata, m_dexp); end
         end
         model_adv();
         next();
      end
      idle();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) phys[i] = init_word(i);
      next();
      test_reset();
      test_cpu_read_alone();
      test_contention();
      test_cpu_write();
      test_dma_stream();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
